// File: rtl/secure_reg_access_ctrl.sv
// Valid/ready front end for the secure register: only thread 0 may touch it,
// other threads are denied and counted, and enough violations lock the block out until reset.
module secure_reg_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int THREAD_W   = 4,
    parameter int MAX_VIOL   = 3,
    parameter int VIOL_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [THREAD_W-1:0]   req_thread_id,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    output logic                  reg_wr_en,
    output logic                  reg_access_en,
    output logic                  reg_thread_id,
    input  logic [DATA_WIDTH-1:0] reg_data_out,
    output logic [VIOL_W-1:0]     viol_count,
    output logic                  locked
);

    localparam logic [VIOL_W-1:0] VIOL_SAT   = {VIOL_W{1'b1}};
    localparam logic [VIOL_W-1:0] VIOL_LIMIT = VIOL_W'(MAX_VIOL);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  write_q;
    logic [THREAD_W-1:0]   thread_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [VIOL_W-1:0]     viol_q;
    logic [VIOL_W-1:0]     viol_inc;
    logic                  locked_q;
    logic                  accept;
    logic                  bad_thread;
    logic                  deny;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign bad_thread = (req_thread_id != '0);
    assign deny       = locked_q || bad_thread;
    assign viol_inc   = (viol_q == VIOL_SAT) ? viol_q : viol_q + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = deny ? RESP : ISSUE;
            ISSUE:   state_next = write_q ? RESP : WAIT_RD;
            WAIT_RD: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write data is only latched for granted requests so reg_data_in never moves outside ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            thread_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            viol_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q  <= req_write;
                thread_q <= req_thread_id;
                rdata_q  <= '0;
                err_q    <= deny;
                if (!deny) wdata_q <= req_wdata;
                if (bad_thread) begin
                    viol_q <= viol_inc;
                    if (viol_inc >= VIOL_LIMIT) locked_q <= 1'b1;
                end
            end
            if (state == WAIT_RD) rdata_q <= reg_data_out;
        end
    end

    // thread_q is rechecked so a corrupted latch can never strobe the register for another thread.
    assign reg_access_en = (state == ISSUE) && (thread_q == '0);
    assign reg_wr_en     = reg_access_en && write_q;
    assign reg_data_in   = wdata_q;
    assign reg_thread_id = 1'b0;
    assign rsp_valid     = (state == RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign viol_count    = viol_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// Scoreboard bench for secure_reg_access_ctrl: directed requests push expected
// responses, a negedge monitor pops and compares them when responses complete.
module tb_secure_reg_access_ctrl;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [TW-1:0] req_thread_id = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [DW-1:0] reg_data_in;
    logic          reg_wr_en;
    logic          reg_access_en;
    logic          reg_thread_id;
    logic [DW-1:0] reg_data_out;
    logic [VW-1:0] viol_count;
    logic          locked;

    secure_reg_access_ctrl #(
        .DATA_WIDTH(DW), .THREAD_W(TW), .MAX_VIOL(3), .VIOL_W(VW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_thread_id(req_thread_id), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_data_in(reg_data_in), .reg_wr_en(reg_wr_en), .reg_access_en(reg_access_en),
        .reg_thread_id(reg_thread_id), .reg_data_out(reg_data_out),
        .viol_count(viol_count), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural secure register: data_out refreshes on a read access.
    logic [DW-1:0] reg_mem = '0;
    logic [DW-1:0] reg_dout = '0;
    assign reg_data_out = reg_dout;
    always @(posedge clk) begin
        if (reg_access_en && reg_thread_id == 1'b0) begin
            if (reg_wr_en) reg_mem <= reg_data_in;
            else           reg_dout <= reg_mem;
        end
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            access_cnt = 0;
    int            wr_cnt = 0;
    logic [DW-1:0] last_wdata = '0;
    logic          rsp_valid_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic failTimeout(input string name);
        n_checks++;
        $display("[TB] FAIL %s: wait bound expired, got no event, required one", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reg_access_en) begin
            access_cnt++;
            checkOutput("reg_thread_id", 64'(reg_thread_id), 64'd0);
        end
        if (reg_wr_en) begin
            wr_cnt++;
            last_wdata = reg_data_in;
            checkOutput("wr_without_access", 64'(reg_access_en), 64'd1);
        end
        if (rsp_valid && !rsp_valid_prev) begin
            if (sb.size() == 0) checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else checkOutput("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
        end
        if (rsp_valid && rsp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
        end
        rsp_valid_prev = rsp_valid;
    end

    task automatic applyStimulus(input logic wr, input logic [TW-1:0] tid, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input bit wait_done);
        int acc0;
        int wr0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            failTimeout("req_ready");
            return;
        end
        acc0 = access_cnt;
        wr0  = wr_cnt;
        req_valid     = 1'b1;
        req_write     = wr;
        req_thread_id = tid;
        req_wdata     = wd;
        sb.push_back('{exp_rdata, exp_err, exp_lat, cyc});
        @(negedge clk);
        req_valid = 1'b0;
        if (wait_done) begin
            for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
            if (sb.size() != 0) begin
                failTimeout("rsp");
                sb.delete();
            end
            checkOutput("access_pulses", 64'(access_cnt - acc0), exp_err ? 64'd0 : 64'd1);
            checkOutput("wr_pulses", 64'(wr_cnt - wr0), (!exp_err && wr) ? 64'd1 : 64'd0);
            if (!exp_err && wr) checkOutput("reg_data_in", 64'(last_wdata), 64'(wd));
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int acc_hold;
        $display("[TB] start");
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_viol", 64'(viol_count), 64'd0);
        checkOutput("rst_locked", 64'(locked), 64'd0);
        checkOutput("rst_access_en", 64'(reg_access_en), 64'd0);
        checkOutput("rst_wr_en", 64'(reg_wr_en), 64'd0);
        checkOutput("rst_data_in", 64'(reg_data_in), 64'd0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 4'd0, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 4'd0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
        applyStimulus(1'b1, 4'd5, 32'h12345678, 32'h0, 1'b1, 1, 1'b1);
        checkOutput("viol_after_t5", 64'(viol_count), 64'd1);
        checkOutput("locked_after_t5", 64'(locked), 64'd0);
        applyStimulus(1'b0, 4'd0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);

        // Lockout from a clean counter: third violation locks, thread 0 then denied.
        resetDut();
        applyStimulus(1'b1, 4'd3, 32'h1, 32'h0, 1'b1, 1, 1'b1);
        checkOutput("viol_1", 64'(viol_count), 64'd1);
        checkOutput("locked_1", 64'(locked), 64'd0);
        applyStimulus(1'b0, 4'd3, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        checkOutput("viol_2", 64'(viol_count), 64'd2);
        checkOutput("locked_2", 64'(locked), 64'd0);
        applyStimulus(1'b1, 4'd3, 32'h2, 32'h0, 1'b1, 1, 1'b1);
        checkOutput("viol_3", 64'(viol_count), 64'd3);
        checkOutput("locked_3", 64'(locked), 64'd1);
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        checkOutput("viol_locked_t0", 64'(viol_count), 64'd3);

        // Back-pressure on a read response; a request during the hold must be ignored.
        resetDut();
        applyStimulus(1'b1, 4'd0, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0);
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        if (!rsp_valid) failTimeout("hold_rsp_valid");
        acc_hold = access_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("hold_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
            if (i == 2) begin
                req_valid     = 1'b1;
                req_write     = 1'b1;
                req_thread_id = 4'd0;
                req_wdata     = 32'h11111111;
            end
            if (i == 8) req_valid = 1'b0;
        end
        checkOutput("hold_no_access", 64'(access_cnt - acc_hold), 64'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failTimeout("hold_release");
            sb.delete();
        end
        applyStimulus(1'b0, 4'd0, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);

        // Reset while a granted write is in ISSUE.
        resetDut();
        applyStimulus(1'b1, 4'd3, 32'h5, 32'h0, 1'b1, 1, 1'b1);
        checkOutput("pre_abort_viol", 64'(viol_count), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid     = 1'b1;
        req_write     = 1'b1;
        req_thread_id = 4'd0;
        req_wdata     = 32'hAAAA5555;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_in_issue", 64'(reg_access_en), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_access_en", 64'(reg_access_en), 64'd0);
        checkOutput("abort_locked", 64'(locked), 64'd0);
        checkOutput("abort_viol", 64'(viol_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("abort_access_after", 64'(reg_access_en), 64'd0);
        checkOutput("abort_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_late_rsp", 64'(rsp_valid), 64'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
